// File: rtl/VX_hpdcache_pkg.sv
// Shared types for the HPDcache <-> Vortex memory bus arbiter.
// The mem bus tag is {is_write, id}, so the tag is one bit wider than the HPDcache id.
package VX_hpdcache_pkg;

   typedef enum logic {
      REQ_RD = 1'b0,
      REQ_WR = 1'b1
   } req_kind_e;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   function automatic int tag_width(input int id_width);
      return id_width + 1;
   endfunction

   function automatic int tag_wr_bit(input int id_width);
      return id_width;
   endfunction

endpackage

// File: rtl/vx_hpdcache_mem_arbiter_if.sv
// Bundle of the HPDcache read/write channels, the mem bus request/response and the acks.
// slave is the arbiter's view; master is the HPDcache plus memory side.
interface vx_hpdcache_mem_arbiter_if
   import VX_hpdcache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 4
);
   localparam int TAG_WIDTH = tag_width(ID_WIDTH);
   localparam int BE_WIDTH  = DATA_WIDTH / 8;

   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [ADDR_WIDTH-1:0] rd_req_addr;
   logic [ID_WIDTH-1:0]   rd_req_id;

   logic                  wr_req_valid;
   logic                  wr_req_ready;
   logic [ADDR_WIDTH-1:0] wr_req_addr;
   logic [ID_WIDTH-1:0]   wr_req_id;

   logic                  wr_dat_valid;
   logic                  wr_dat_ready;
   logic [DATA_WIDTH-1:0] wr_dat_data;
   logic [BE_WIDTH-1:0]   wr_dat_be;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_rw;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_req_data;
   logic [BE_WIDTH-1:0]   mem_req_byteen;
   logic [TAG_WIDTH-1:0]  mem_req_tag;

   logic                  mem_rsp_valid;
   logic                  mem_rsp_ready;
   logic [DATA_WIDTH-1:0] mem_rsp_data;
   logic [TAG_WIDTH-1:0]  mem_rsp_tag;

   logic                  rd_rsp_valid;
   logic                  rd_rsp_ready;
   logic [ID_WIDTH-1:0]   rd_rsp_id;
   logic [DATA_WIDTH-1:0] rd_rsp_data;

   logic                  wr_rsp_valid;
   logic                  wr_rsp_ready;
   logic [ID_WIDTH-1:0]   wr_rsp_id;

   modport slave (
      input  rd_req_valid, rd_req_addr, rd_req_id,
      output rd_req_ready,
      input  wr_req_valid, wr_req_addr, wr_req_id,
      output wr_req_ready,
      input  wr_dat_valid, wr_dat_data, wr_dat_be,
      output wr_dat_ready,
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      output mem_rsp_ready,
      output rd_rsp_valid, rd_rsp_id, rd_rsp_data,
      input  rd_rsp_ready,
      output wr_rsp_valid, wr_rsp_id,
      input  wr_rsp_ready
   );

   modport master (
      output rd_req_valid, rd_req_addr, rd_req_id,
      input  rd_req_ready,
      output wr_req_valid, wr_req_addr, wr_req_id,
      input  wr_req_ready,
      output wr_dat_valid, wr_dat_data, wr_dat_be,
      input  wr_dat_ready,
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      input  mem_rsp_ready,
      input  rd_rsp_valid, rd_rsp_id, rd_rsp_data,
      output rd_rsp_ready,
      input  wr_rsp_valid, wr_rsp_id,
      output wr_rsp_ready
   );

endinterface

// File: rtl/VX_fifo_queue.sv
// Small synchronous FIFO holding the ids of accepted writes until their acks are taken.
// DEPTH must be a power of two so the pointers wrap naturally.
module VX_fifo_queue #(
   parameter int DATAW = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             empty,
   output logic             full
);
   localparam int PTRW = $clog2(DEPTH);

   logic [DATAW-1:0] storage [DEPTH];
   logic [PTRW-1:0]  wr_ptr;
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW:0]    count;
   logic             do_push;
   logic             do_pop;

   // A push into a full queue is only taken when the same cycle frees a slot.
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign empty    = (count == '0);
   assign full     = (count == (PTRW+1)'(DEPTH));
   assign data_out = storage[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PTRW{1'b0}}, do_push} - {{PTRW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) storage[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/vx_hpdcache_mem_arbiter.sv
// Round-robin merge of HPDcache read and write channels onto one registered Vortex mem bus port.
// Read responses are routed back by tag; write acks come from a local FIFO in accept order.
module vx_hpdcache_mem_arbiter
   import VX_hpdcache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 4,
   parameter int WACK_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   vx_hpdcache_mem_arbiter_if.slave bus
);
   localparam int TAG_WIDTH  = tag_width(ID_WIDTH);
   localparam int TAG_WR_BIT = tag_wr_bit(ID_WIDTH);
   localparam int BE_WIDTH   = DATA_WIDTH / 8;

   out_state_e            out_state;
   req_kind_e             rr_ptr;
   req_kind_e             req_kind;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic [BE_WIDTH-1:0]   req_byteen;
   logic [TAG_WIDTH-1:0]  req_tag;

   logic                  rd_elig;
   logic                  wr_elig;
   logic                  load_en;
   logic                  grant_rd;
   logic                  grant_wr;
   logic                  ack_full;
   logic                  ack_empty;
   logic                  ack_pop;
   logic [ID_WIDTH-1:0]   ack_id;
   logic                  is_wr_rsp;

   // A write only qualifies with both halves present and room for its ack.
   always_comb begin
      rd_elig  = bus.rd_req_valid;
      wr_elig  = bus.wr_req_valid & bus.wr_dat_valid & ~ack_full;
      load_en  = reset & ((out_state == OUT_EMPTY) | bus.mem_req_ready);
      grant_rd = load_en & rd_elig & (~wr_elig | (rr_ptr == REQ_RD));
      grant_wr = load_en & wr_elig & ~grant_rd;
   end

   assign bus.rd_req_ready = grant_rd;
   assign bus.wr_req_ready = grant_wr;
   assign bus.wr_dat_ready = grant_wr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_state  <= OUT_EMPTY;
         rr_ptr     <= REQ_RD;
         req_kind   <= REQ_RD;
         req_addr   <= '0;
         req_data   <= '0;
         req_byteen <= '0;
         req_tag    <= '0;
      end else if (grant_rd) begin
         out_state  <= OUT_FULL;
         rr_ptr     <= REQ_WR;
         req_kind   <= REQ_RD;
         req_addr   <= bus.rd_req_addr;
         req_data   <= '0;
         req_byteen <= '1;
         req_tag    <= {1'b0, bus.rd_req_id};
      end else if (grant_wr) begin
         out_state  <= OUT_FULL;
         rr_ptr     <= REQ_RD;
         req_kind   <= REQ_WR;
         req_addr   <= bus.wr_req_addr;
         req_data   <= bus.wr_dat_data;
         req_byteen <= bus.wr_dat_be;
         req_tag    <= {1'b1, bus.wr_req_id};
      end else if ((out_state == OUT_FULL) && bus.mem_req_ready) begin
         out_state  <= OUT_EMPTY;
      end
   end

   assign bus.mem_req_valid  = (out_state == OUT_FULL);
   assign bus.mem_req_rw     = (req_kind == REQ_WR);
   assign bus.mem_req_addr   = req_addr;
   assign bus.mem_req_data   = req_data;
   assign bus.mem_req_byteen = req_byteen;
   assign bus.mem_req_tag    = req_tag;

   // Write responses are never expected from the bus; they are swallowed so the bus cannot stall.
   assign is_wr_rsp         = bus.mem_rsp_tag[TAG_WR_BIT];
   assign bus.mem_rsp_ready = reset & (is_wr_rsp | bus.rd_rsp_ready);
   assign bus.rd_rsp_valid  = reset & bus.mem_rsp_valid & ~is_wr_rsp;
   assign bus.rd_rsp_id     = bus.mem_rsp_tag[ID_WIDTH-1:0];
   assign bus.rd_rsp_data   = bus.mem_rsp_data;

   assign bus.wr_rsp_valid = reset & ~ack_empty;
   assign bus.wr_rsp_id    = ack_id;
   assign ack_pop          = bus.wr_rsp_valid & bus.wr_rsp_ready;

   VX_fifo_queue #(
      .DATAW (ID_WIDTH),
      .DEPTH (WACK_DEPTH)
   ) ack_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (grant_wr),
      .pop      (ack_pop),
      .data_in  (bus.wr_req_id),
      .data_out (ack_id),
      .empty    (ack_empty),
      .full     (ack_full)
   );

   always_ff @(posedge clk) begin
      if (reset && bus.mem_rsp_valid) begin
         assert (!is_wr_rsp) else $error("unexpected write response on the memory bus");
      end
   end

endmodule

// File: tb/tb_vx_hpdcache_mem_arbiter.sv
// Bench for vx_hpdcache_mem_arbiter: directed scenarios plus random traffic against a queue-based model.
// Inputs change 1ns after the rising edge; outputs are checked 4ns after it.
module tb_vx_hpdcache_mem_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int IW   = 4;
   localparam int WACK = 4;
   localparam int BW   = DW / 8;

   typedef struct {
      bit            rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
      logic [IW:0]   tag;
   } req_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   req_t          exp_q[$];
   logic [IW-1:0] ack_q[$];
   bit            last_was_rd = 1'b0;
   bit            seen_rd_rdy;
   bit            seen_wr_rdy;
   bit            seen_ack_pop;
   logic [IW-1:0] seen_ack_id;

   always #5 clk = ~clk;

   vx_hpdcache_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   vx_hpdcache_mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .WACK_DEPTH (WACK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic idle_inputs();
      bus.rd_req_valid  = 1'b0;
      bus.rd_req_addr   = '0;
      bus.rd_req_id     = '0;
      bus.wr_req_valid  = 1'b0;
      bus.wr_req_addr   = '0;
      bus.wr_req_id     = '0;
      bus.wr_dat_valid  = 1'b0;
      bus.wr_dat_data   = '0;
      bus.wr_dat_be     = '0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.mem_rsp_tag   = '0;
      bus.rd_rsp_ready  = 1'b1;
      bus.wr_rsp_ready  = 1'b1;
   endtask

   // One clock of the reference model: predict grants and outputs, compare, then advance.
   task automatic applyStimulus();
      bit   in_rst, slot_free, rd_ok, wr_ok, g_rd, g_wr, pop_req, pop_ack;
      req_t r;
      logic [IW-1:0] wid;
      #3;
      in_rst    = (reset == 1'b0);
      slot_free = (exp_q.size() == 0) || (bus.mem_req_ready == 1'b1);
      rd_ok     = (bus.rd_req_valid == 1'b1);
      wr_ok     = (bus.wr_req_valid == 1'b1) && (bus.wr_dat_valid == 1'b1) && (ack_q.size() < WACK);
      g_rd      = !in_rst && slot_free && rd_ok && (!wr_ok || !last_was_rd);
      g_wr      = !in_rst && slot_free && wr_ok && !g_rd;
      seen_rd_rdy = bus.rd_req_ready;
      seen_wr_rdy = bus.wr_req_ready;
      checkOutput("rd_req_ready", bus.rd_req_ready, g_rd);
      checkOutput("wr_req_ready", bus.wr_req_ready, g_wr);
      checkOutput("wr_dat_ready", bus.wr_dat_ready, g_wr);
      checkOutput("mem_req_valid", bus.mem_req_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         checkOutput("mem_req_rw", bus.mem_req_rw, exp_q[0].rw);
         checkOutput("mem_req_addr", bus.mem_req_addr, exp_q[0].addr);
         checkOutput("mem_req_data", bus.mem_req_data, exp_q[0].data);
         checkOutput("mem_req_byteen", bus.mem_req_byteen, exp_q[0].be);
         checkOutput("mem_req_tag", bus.mem_req_tag, exp_q[0].tag);
      end
      checkOutput("wr_rsp_valid", bus.wr_rsp_valid, !in_rst && ack_q.size() != 0);
      pop_ack      = !in_rst && (ack_q.size() != 0) && (bus.wr_rsp_ready == 1'b1);
      seen_ack_pop = pop_ack;
      if (!in_rst && ack_q.size() != 0) begin
         checkOutput("wr_rsp_id", bus.wr_rsp_id, ack_q[0]);
         seen_ack_id = bus.wr_rsp_id;
      end
      checkOutput("rd_rsp_valid", bus.rd_rsp_valid, !in_rst && bus.mem_rsp_valid);
      checkOutput("mem_rsp_ready", bus.mem_rsp_ready, !in_rst && bus.rd_rsp_ready);
      if (!in_rst && bus.mem_rsp_valid) begin
         checkOutput("rd_rsp_id", bus.rd_rsp_id, bus.mem_rsp_tag[IW-1:0]);
         checkOutput("rd_rsp_data", bus.rd_rsp_data, bus.mem_rsp_data);
      end
      pop_req = (exp_q.size() != 0) && (bus.mem_req_ready == 1'b1);
      wid     = bus.wr_req_id;
      if (g_rd) begin
         r.rw = 1'b0; r.addr = bus.rd_req_addr; r.data = '0; r.be = '1; r.tag = {1'b0, bus.rd_req_id};
      end else begin
         r.rw = 1'b1; r.addr = bus.wr_req_addr; r.data = bus.wr_dat_data; r.be = bus.wr_dat_be;
         r.tag = {1'b1, bus.wr_req_id};
      end
      @(posedge clk);
      if (in_rst) begin
         exp_q.delete();
         ack_q.delete();
         last_was_rd = 1'b0;
      end else begin
         if (pop_req) void'(exp_q.pop_front());
         if (pop_ack) void'(ack_q.pop_front());
         if (g_rd || g_wr) exp_q.push_back(r);
         if (g_wr) ack_q.push_back(wid);
         if (g_rd) last_was_rd = 1'b1;
         if (g_wr) last_was_rd = 1'b0;
      end
      #1;
   endtask

   task automatic reset_dut();
      idle_inputs();
      reset = 1'b0;
      applyStimulus();
      reset = 1'b1;
   endtask

   initial begin
      logic [IW-1:0] issued[4];
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus();
      reset = 1'b1;

      // Single read, then its response
      bus.rd_req_valid = 1'b1; bus.rd_req_id = 4'd3; bus.rd_req_addr = 32'h100;
      applyStimulus();
      idle_inputs();
      checkOutput("t1_tag", bus.mem_req_tag, 64'h03);
      checkOutput("t1_byteen", bus.mem_req_byteen, 64'hFF);
      applyStimulus();
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 5'h03; bus.mem_rsp_data = 64'hDEADBEEF_CAFEF00D;
      applyStimulus();
      checkOutput("t1_rsp_id_seen", {63'd0, seen_rd_rdy}, 64'd0);

      // Both channels busy every cycle: strict alternation starting with read
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         bus.rd_req_valid = 1'b1; bus.rd_req_id = IW'(i); bus.rd_req_addr = 32'h1000 + 32'(i * 64);
         bus.wr_req_valid = 1'b1; bus.wr_req_id = IW'(i + 8); bus.wr_req_addr = 32'h2000 + 32'(i * 64);
         bus.wr_dat_valid = 1'b1; bus.wr_dat_data = {$urandom, $urandom}; bus.wr_dat_be = 8'(i * 37 + 1);
         applyStimulus();
         checkOutput("t2_alt_rd", seen_rd_rdy, (i % 2) == 0);
         checkOutput("t2_alt_wr", seen_wr_rdy, (i % 2) == 1);
      end

      // Write request waiting for its data
      idle_inputs();
      applyStimulus();
      bus.wr_req_valid = 1'b1; bus.wr_req_id = 4'd5; bus.wr_req_addr = 32'h3000;
      bus.wr_dat_data = 64'h0123_4567_89AB_CDEF; bus.wr_dat_be = 8'h0F;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("t3_no_wr_ready", seen_wr_rdy, 1'b0);
      end
      bus.wr_dat_valid = 1'b1;
      applyStimulus();
      checkOutput("t3_wr_ready", seen_wr_rdy, 1'b1);
      idle_inputs();
      checkOutput("t3_tag", bus.mem_req_tag, 64'h15);

      // Bus back-pressure holds the registered request
      bus.mem_req_ready = 1'b0;
      bus.rd_req_valid = 1'b1; bus.rd_req_id = 4'd7; bus.rd_req_addr = 32'h200;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("t4_rd_stall", seen_rd_rdy, 1'b0);
      end
      bus.mem_req_ready = 1'b1;
      applyStimulus();
      idle_inputs();
      repeat (2) applyStimulus();

      // Ack FIFO fills: writes stall while reads continue, then acks drain in order
      reset_dut();
      bus.wr_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issued[i] = IW'(i + 1);
         bus.wr_req_valid = 1'b1; bus.wr_dat_valid = 1'b1; bus.wr_req_id = issued[i];
         bus.wr_req_addr = 32'h4000 + 32'(i * 64); bus.wr_dat_data = {$urandom, $urandom}; bus.wr_dat_be = 8'hFF;
         applyStimulus();
      end
      bus.wr_req_id = 4'd9; bus.rd_req_valid = 1'b1; bus.rd_req_id = 4'd2;
      for (int i = 0; i < 3; i++) begin
         bus.rd_req_addr = 32'h5000 + 32'(i * 64);
         applyStimulus();
         checkOutput("t5_wr_stall", seen_wr_rdy, 1'b0);
         checkOutput("t5_rd_go", seen_rd_rdy, 1'b1);
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("t5_ack_pop", seen_ack_pop, 1'b1);
         checkOutput("t5_ack_order", seen_ack_id, issued[i]);
      end
      applyStimulus();

      // Reset while a request is held and two acks are pending
      bus.wr_rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.wr_req_valid = 1'b1; bus.wr_dat_valid = 1'b1; bus.wr_req_id = IW'(10 + i);
         bus.wr_req_addr = 32'h6000 + 32'(i * 64); bus.wr_dat_data = {$urandom, $urandom}; bus.wr_dat_be = 8'hA5;
         applyStimulus();
      end
      bus.wr_req_valid = 1'b0; bus.wr_dat_valid = 1'b0; bus.mem_req_ready = 1'b0;
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      reset = 1'b1;
      idle_inputs();
      checkOutput("t6_mem_req_valid", bus.mem_req_valid, 1'b0);
      checkOutput("t6_wr_rsp_valid", bus.wr_rsp_valid, 1'b0);
      checkOutput("t6_rd_rsp_valid", bus.rd_rsp_valid, 1'b0);
      applyStimulus();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bus.rd_req_valid  = ($urandom_range(0, 99) < 60);
         bus.rd_req_addr   = $urandom;
         bus.rd_req_id     = IW'($urandom);
         bus.wr_req_valid  = ($urandom_range(0, 99) < 60);
         bus.wr_req_addr   = $urandom;
         bus.wr_req_id     = IW'($urandom);
         bus.wr_dat_valid  = ($urandom_range(0, 99) < 70);
         bus.wr_dat_data   = {$urandom, $urandom};
         bus.wr_dat_be     = BW'($urandom);
         bus.mem_req_ready = ($urandom_range(0, 99) < 70);
         bus.mem_rsp_valid = ($urandom_range(0, 99) < 40);
         bus.mem_rsp_tag   = {1'b0, IW'($urandom)};
         bus.mem_rsp_data  = {$urandom, $urandom};
         bus.rd_rsp_ready  = ($urandom_range(0, 99) < 70);
         bus.wr_rsp_ready  = ($urandom_range(0, 99) < 40);
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
